// File: rtl/nor_cmd_seq_if.sv
// Wishbone write-master bus between the NOR command sequencer and the
// parallel NOR bus block's memory port.
`ifndef NORADDRBITS
`define NORADDRBITS 24
`endif
`ifndef NORDATABITS
`define NORDATABITS 16
`endif

interface nor_cmd_seq_if #(
  parameter int ADDRBITS = `NORADDRBITS,
  parameter int DATABITS = `NORDATABITS
);
  logic                cyc;
  logic                stb;
  logic                we;
  logic [ADDRBITS-1:0] adr;
  logic [DATABITS-1:0] dat;
  logic                ack;
  logic                stall;
  logic                err;

  modport master (output cyc, stb, we, adr, dat, input ack, stall, err);
  modport slave  (input cyc, stb, we, adr, dat, output ack, stall, err);
endinterface

// File: rtl/nor_cmd_seq.sv
// NOR flash command sequencer: expands RESET / PROGRAM / SECTOR_ERASE /
// CHIP_ERASE into JEDEC unlock write sequences on a pipelined Wishbone
// master, then waits on RY/BY# with blanking and an optional timeout.
`ifndef NORADDRBITS
`define NORADDRBITS 24
`endif
`ifndef NORDATABITS
`define NORDATABITS 16
`endif

module nor_cmd_seq #(
  parameter int ADDRBITS = `NORADDRBITS,
  parameter int DATABITS = `NORDATABITS,
  parameter int RYBLANK  = 8
) (
  input  logic                sys_clk_i,
  input  logic                sys_rstn_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [2:0]          cmd_op_i,
  input  logic [ADDRBITS-1:0] cmd_addr_i,
  input  logic [DATABITS-1:0] cmd_data_i,
  input  logic [31:0]         cmd_limit_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          status_o,
  input  logic                nor_ry_i,
  nor_cmd_seq_if.master       memwb
);

  localparam logic [2:0] OP_RESET   = 3'd0;
  localparam logic [2:0] OP_PROGRAM = 3'd1;
  localparam logic [2:0] OP_SECTOR  = 3'd2;
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_BUSERR  = 2'd2;
  localparam logic [1:0] ST_BADOP   = 2'd3;
  localparam int         BW         = $clog2(RYBLANK + 1);
  localparam logic [ADDRBITS-1:0] A555 = ADDRBITS'(12'h555);
  localparam logic [ADDRBITS-1:0] A2AA = ADDRBITS'(12'h2AA);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_STB, S_WR_ACK, S_BLANK, S_POLL, S_RECOVER, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [DATABITS-1:0] data_q, data_d;
  logic [31:0]         limit_q, limit_d;
  logic [2:0]          step_q, step_d;
  logic                rec_q, rec_d;
  logic [1:0]          status_q, status_d;
  logic [BW-1:0]       blank_q, blank_d;
  logic [31:0]         tmo_q, tmo_d;
  logic                hit_q, hit_d;
  logic [ADDRBITS-1:0] adr_q, adr_d;
  logic [DATABITS-1:0] dat_q, dat_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                ry_meta_q, ry_sync_q;
  logic                wr_go;
  logic                tmo_now;

  // Index of the final write of a sequence; the recovery sequence is one write.
  function automatic logic [2:0] last_step(input logic [2:0] op, input logic rec);
    if (rec || op == OP_RESET) return 3'd0;
    else if (op == OP_PROGRAM) return 3'd3;
    else                       return 3'd5;
  endfunction

  function automatic logic [ADDRBITS-1:0] step_adr(input logic [2:0] op, input logic [2:0] step,
                                                   input logic rec, input logic [ADDRBITS-1:0] addr);
    if (rec || op == OP_RESET) return addr;
    case (step)
      3'd0:    return A555;
      3'd1:    return A2AA;
      3'd2:    return A555;
      3'd3:    return (op == OP_PROGRAM) ? addr : A555;
      3'd4:    return A2AA;
      default: return (op == OP_SECTOR) ? addr : A555;
    endcase
  endfunction

  function automatic logic [DATABITS-1:0] step_dat(input logic [2:0] op, input logic [2:0] step,
                                                   input logic rec, input logic [DATABITS-1:0] data);
    if (rec || op == OP_RESET) return DATABITS'(8'hF0);
    case (step)
      3'd0:    return DATABITS'(8'hAA);
      3'd1:    return DATABITS'(8'h55);
      3'd2:    return (op == OP_PROGRAM) ? DATABITS'(8'hA0) : DATABITS'(8'h80);
      3'd3:    return (op == OP_PROGRAM) ? data : DATABITS'(8'hAA);
      3'd4:    return DATABITS'(8'h55);
      default: return (op == OP_SECTOR) ? DATABITS'(8'h30) : DATABITS'(8'h10);
    endcase
  endfunction

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    limit_d  = limit_q;
    step_d   = step_q;
    rec_d    = rec_q;
    status_d = status_q;
    blank_d  = blank_q;
    tmo_d    = tmo_q;
    hit_d    = hit_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    wr_go    = 1'b0;
    tmo_now  = (limit_q != 32'd0) && (tmo_q == limit_q);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          op_d     = cmd_op_i;
          addr_d   = cmd_addr_i;
          data_d   = cmd_data_i;
          limit_d  = cmd_limit_i;
          status_d = ST_OK;
          step_d   = 3'd0;
          rec_d    = 1'b0;
          if (!cmd_op_i[2]) begin
            state_d = S_WR_STB;
            adr_d   = step_adr(cmd_op_i, 3'd0, 1'b0, cmd_addr_i);
            dat_d   = step_dat(cmd_op_i, 3'd0, 1'b0, cmd_data_i);
          end else begin
            state_d  = S_DONE;
            status_d = ST_BADOP;
          end
        end
      end
      S_WR_STB: begin
        if (memwb.err) begin
          status_d = ST_BUSERR;
          state_d  = S_DONE;
        end else if (!memwb.stall) begin
          if (memwb.ack) wr_go = 1'b1;
          else           state_d = S_WR_ACK;
        end
      end
      S_WR_ACK: begin
        if (memwb.err) begin
          status_d = ST_BUSERR;
          state_d  = S_DONE;
        end else if (memwb.ack) begin
          wr_go = 1'b1;
        end
      end
      S_BLANK: begin
        if (tmo_q != 32'hFFFF_FFFF) tmo_d = tmo_q + 32'd1;
        if (tmo_now) hit_d = 1'b1;
        if (blank_q == BW'(RYBLANK - 1)) state_d = S_POLL;
        else                             blank_d = blank_q + BW'(1);
      end
      S_POLL: begin
        if (tmo_q != 32'hFFFF_FFFF) tmo_d = tmo_q + 32'd1;
        if (ry_sync_q) begin
          state_d = S_DONE;
        end else if (hit_q || tmo_now) begin
          state_d  = S_RECOVER;
          status_d = ST_TIMEOUT;
        end
      end
      S_RECOVER: begin
        rec_d   = 1'b1;
        step_d  = 3'd0;
        state_d = S_WR_STB;
        adr_d   = addr_q;
        dat_d   = DATABITS'(8'hF0);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A write completed: move to the next step or leave the write phase.
    if (wr_go) begin
      if (step_q == last_step(op_q, rec_q)) begin
        if (rec_q || op_q == OP_RESET) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BLANK;
          blank_d = '0;
          tmo_d   = 32'd0;
          hit_d   = 1'b0;
        end
      end else begin
        step_d  = step_q + 3'd1;
        state_d = S_WR_STB;
        adr_d   = step_adr(op_q, step_q + 3'd1, rec_q, addr_q);
        dat_d   = step_dat(op_q, step_q + 3'd1, rec_q, data_q);
      end
    end

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    cyc_d   = (state_d == S_WR_STB) || (state_d == S_WR_ACK);
    stb_d   = (state_d == S_WR_STB);
  end

  // State, datapath, output registers and RY synchronizer.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      addr_q    <= '0;
      data_q    <= '0;
      limit_q   <= 32'd0;
      step_q    <= 3'd0;
      rec_q     <= 1'b0;
      status_q  <= ST_OK;
      blank_q   <= '0;
      tmo_q     <= 32'd0;
      hit_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      ry_meta_q <= 1'b0;
      ry_sync_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      limit_q   <= limit_d;
      step_q    <= step_d;
      rec_q     <= rec_d;
      status_q  <= status_d;
      blank_q   <= blank_d;
      tmo_q     <= tmo_d;
      hit_q     <= hit_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      ry_meta_q <= nor_ry_i;
      ry_sync_q <= ry_meta_q;
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign status_o    = status_q;
  assign memwb.cyc   = cyc_q;
  assign memwb.stb   = stb_q;
  assign memwb.we    = stb_q;
  assign memwb.adr   = adr_q;
  assign memwb.dat   = dat_q;

endmodule

// File: tb/tb_nor_cmd_seq.sv
// Directed testbench for nor_cmd_seq with a small Wishbone slave model.
module tb_nor_cmd_seq;
  localparam int AB = 24;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [AB-1:0] cmd_addr = '0;
  logic [DB-1:0] cmd_data = '0;
  logic [31:0]   cmd_limit = 32'd0;
  logic          busy;
  logic          done;
  logic [1:0]    status;
  logic          ry = 1'b0;

  always #5 clk = ~clk;

  nor_cmd_seq_if #(.ADDRBITS(AB), .DATABITS(DB)) wb ();

  nor_cmd_seq #(.ADDRBITS(AB), .DATABITS(DB), .RYBLANK(8)) dut (
    .sys_clk_i   (clk),
    .sys_rstn_i  (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_addr_i  (cmd_addr),
    .cmd_data_i  (cmd_data),
    .cmd_limit_i (cmd_limit),
    .busy_o      (busy),
    .done_o      (done),
    .status_o    (status),
    .nor_ry_i    (ry),
    .memwb       (wb)
  );

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wishbone slave model: ack one cycle after an accepted stb, optional stall and err.
  logic [AB-1:0] log_adr [64];
  logic [DB-1:0] log_dat [64];
  int            acc_cyc [64];
  int            ack_cyc [64];
  int            widx = 0;
  int            err_cyc = -1;
  int            err_at = -1;
  int            stall_at = -1;
  int            stall_len = 0;
  int            stalls_done = 0;
  int            stall_total = 0;
  int            stall_bad = 0;
  int            we_bad = 0;
  int            cyc_rises = 0;
  logic          cyc_prev = 1'b0;
  bit            acc_prev = 1'b0;
  int            acc_prev_idx = 0;
  logic [AB-1:0] st_adr = '0;
  logic [DB-1:0] st_dat = '0;

  initial begin
    wb.ack = 1'b0; wb.stall = 1'b0; wb.err = 1'b0;
    forever begin
      @(negedge clk);
      wb.ack = 1'b0;
      wb.err = 1'b0;
      if (acc_prev) begin
        if (acc_prev_idx == err_at) begin
          wb.err = 1'b1; err_cyc = cycle_cnt;
        end else begin
          wb.ack = 1'b1; ack_cyc[acc_prev_idx % 64] = cycle_cnt;
        end
      end
      if (wb.cyc && !cyc_prev) cyc_rises++;
      cyc_prev = wb.cyc;
      wb.stall = 1'b0;
      acc_prev = 1'b0;
      if (wb.cyc && wb.stb) begin
        if (widx == stall_at && stalls_done < stall_len) begin
          if (stalls_done == 0) begin
            st_adr = wb.adr; st_dat = wb.dat;
          end else if (wb.adr !== st_adr || wb.dat !== st_dat) begin
            stall_bad++;
          end
          wb.stall = 1'b1;
          stalls_done++;
          stall_total++;
        end else begin
          if (stalls_done > 0 && (wb.adr !== st_adr || wb.dat !== st_dat)) stall_bad++;
          if (!wb.we) we_bad++;
          log_adr[widx % 64] = wb.adr;
          log_dat[widx % 64] = wb.dat;
          acc_cyc[widx % 64] = cycle_cnt;
          acc_prev = 1'b1;
          acc_prev_idx = widx;
          widx++;
          stalls_done = 0;
        end
      end
    end
  end

  logic [AB-1:0] ea [8];
  logic [DB-1:0] ed [8];

  task automatic check_log(input string nm, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_adr%0d", nm, i), 32'(log_adr[(base + i) % 64]), 32'(ea[i]));
      check_eq($sformatf("%s_dat%0d", nm, i), 32'(log_dat[(base + i) % 64]), 32'(ed[i]));
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [AB-1:0] addr,
                       input logic [DB-1:0] data, input logic [31:0] limit);
    int k;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk); #1; k++;
    end
    check_eq("ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_limit = limit;
    cmd_valid = 1'b1;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int max, output int ncyc);
    ncyc = 0;
    while (!done && ncyc < max) begin
      @(negedge clk); #1; ncyc++;
    end
    check_eq({nm, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic set_exp(input int i, input logic [AB-1:0] a, input logic [DB-1:0] d);
    ea[i] = a; ed[i] = d;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int rises0;
    int stall0;
    int early;
    int done_cyc;

    // Reset state
    #1;
    @(negedge clk); #1;
    check_eq("reset_outs", 32'({cmd_ready, busy, done, status, wb.cyc, wb.stb, wb.we}), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_eq("ready_after_reset", 32'({cmd_ready, busy}), 32'b10);

    // PROGRAM 0x1234 / 0xBEEF
    ry = 1'b0; base = widx; rises0 = cyc_rises;
    issue(3'd1, 24'h1234, 16'hBEEF, 32'd0);
    check_eq("p_first_ctrl", 32'({wb.cyc, wb.stb, wb.we}), 32'b111);
    check_eq("p_first_adr", 32'(wb.adr), 32'h555);
    check_eq("p_ready_busy", 32'({cmd_ready, busy}), 32'b01);
    repeat (19) @(negedge clk);
    #1;
    ry = 1'b1;
    wait_done("p", 10, n);
    check_eq("p_ry_to_done", 32'(n), 32'd3);
    check_eq("p_status", 32'(status), 32'd0);
    check_eq("p_nwrites", 32'(widx - base), 32'd4);
    check_eq("p_cyc_continuous", 32'(cyc_rises - rises0), 32'd1);
    set_exp(0, 24'h555, 16'hAA); set_exp(1, 24'h2AA, 16'h55);
    set_exp(2, 24'h555, 16'hA0); set_exp(3, 24'h1234, 16'hBEEF);
    check_log("p", base, 4);
    @(negedge clk); #1;
    check_eq("p_done_pulse", 32'({done, cmd_ready}), 32'b01);

    // SECTOR_ERASE 0x8000 with a 3-cycle stall on the second write and an RY glitch in blanking
    ry = 1'b0; base = widx; stall0 = stall_total;
    stall_at = widx + 1; stall_len = 3;
    issue(3'd2, 24'h8000, 16'h0, 32'd0);
    n = 0;
    while (!((widx - base) == 6 && !wb.cyc) && n < 80) begin
      @(negedge clk); #1; n++;
    end
    check_eq("se_blank_reached", 32'({wb.cyc, busy}), 32'b01);
    ry = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    ry = 1'b0;
    early = 0;
    repeat (12) begin
      @(negedge clk); #1;
      if (done) early++;
    end
    check_eq("se_ry_blanked", 32'(early), 32'd0);
    ry = 1'b1;
    wait_done("se", 10, n);
    check_eq("se_ry_to_done", 32'(n), 32'd3);
    check_eq("se_status", 32'(status), 32'd0);
    check_eq("se_nwrites", 32'(widx - base), 32'd6);
    check_eq("se_stall_cycles", 32'(stall_total - stall0), 32'd3);
    check_eq("se_stall_stable", 32'(stall_bad), 32'd0);
    set_exp(0, 24'h555, 16'hAA); set_exp(1, 24'h2AA, 16'h55);
    set_exp(2, 24'h555, 16'h80); set_exp(3, 24'h555, 16'hAA);
    set_exp(4, 24'h2AA, 16'h55); set_exp(5, 24'h8000, 16'h30);
    check_log("se", base, 6);
    stall_at = -1; stall_len = 0;

    // PROGRAM with RY stuck low and limit 100 -> TIMEOUT with recovery write
    ry = 1'b0; base = widx;
    issue(3'd1, 24'h1234, 16'hBEEF, 32'd100);
    wait_done("to", 300, n);
    check_eq("to_status", 32'(status), 32'd1);
    check_eq("to_nwrites", 32'(widx - base), 32'd5);
    set_exp(4, 24'h1234, 16'hF0);
    set_exp(0, 24'h555, 16'hAA); set_exp(1, 24'h2AA, 16'h55);
    set_exp(2, 24'h555, 16'hA0); set_exp(3, 24'h1234, 16'hBEEF);
    check_log("to", base, 5);
    check_eq("to_latency", 32'(acc_cyc[(base + 4) % 64] - ack_cyc[(base + 3) % 64]), 32'd103);
    @(negedge clk); #1;
    check_eq("to_status_held", 32'({done, status}), 32'b001);

    // CHIP_ERASE with a bus error on the third write
    base = widx; err_at = widx + 2;
    issue(3'd3, 24'h0, 16'h0, 32'd0);
    wait_done("ce", 50, n);
    done_cyc = cycle_cnt;
    check_eq("ce_cyc_dropped", 32'({wb.cyc, wb.stb}), 32'd0);
    check_eq("ce_err_to_done", 32'(done_cyc - err_cyc), 32'd1);
    check_eq("ce_status", 32'(status), 32'd2);
    repeat (5) @(negedge clk);
    #1;
    check_eq("ce_nwrites", 32'(widx - base), 32'd3);
    set_exp(0, 24'h555, 16'hAA); set_exp(1, 24'h2AA, 16'h55); set_exp(2, 24'h555, 16'h80);
    check_log("ce", base, 3);
    err_at = -1;

    // Illegal op
    base = widx; rises0 = cyc_rises;
    issue(3'd5, 24'h77, 16'h0, 32'd0);
    check_eq("bad_done_status", 32'({done, status, wb.cyc}), 32'b1110);
    @(negedge clk); #1;
    check_eq("bad_done_pulse", 32'({done, cmd_ready}), 32'b01);
    check_eq("bad_no_bus", 32'((widx - base) + (cyc_rises - rises0)), 32'd0);

    // RESET op: single F0 write, no RY wait
    ry = 1'b0; base = widx;
    issue(3'd0, 24'h42, 16'h0, 32'd0);
    wait_done("rs", 20, n);
    check_eq("rs_ack_to_done", 32'(cycle_cnt - ack_cyc[base % 64]), 32'd1);
    check_eq("rs_status", 32'(status), 32'd0);
    check_eq("rs_nwrites", 32'(widx - base), 32'd1);
    set_exp(0, 24'h42, 16'hF0);
    check_log("rs", base, 1);
    check_eq("we_with_stb", 32'(we_bad), 32'd0);

    // Asynchronous reset in the middle of POLL
    ry = 1'b0;
    issue(3'd1, 24'h1234, 16'hBEEF, 32'd0);
    repeat (20) @(negedge clk);
    #1;
    check_eq("rp_in_poll", 32'({busy, wb.cyc}), 32'b10);
    rst_n = 1'b0;
    #1;
    check_eq("rp_outs_zero", 32'({cmd_ready, busy, done, status, wb.cyc, wb.stb, wb.we}), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_eq("rp_ready_after", 32'({cmd_ready, busy}), 32'b10);

    // Asynchronous reset while a write is stalled in WR_STB
    stall_at = widx; stall_len = 1000;
    issue(3'd1, 24'h1234, 16'hBEEF, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("rw_in_stb", 32'({wb.cyc, wb.stb}), 32'b11);
    rst_n = 1'b0;
    #1;
    check_eq("rw_outs_zero", 32'({cmd_ready, busy, done, status, wb.cyc, wb.stb, wb.we}), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_eq("rw_ready_after", 32'({cmd_ready, busy, wb.cyc}), 32'b100);
    stall_len = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
